// File: rtl/a2d_spi_responder.sv
// a2d_spi_responder: SPI slave model of the 8-channel, 12-bit A2D converter
// on the e-bike A2D link. Each 16-bit frame shifts in a command whose bits
// [13:11] select a channel. The following frame shifts out that channel's
// conversion result, which is snapshotted when the command frame completes.
//
// Optional build macro A2D_CHAN_TAG_EN: when defined, response bits [15:12]
// carry {1'b0, channel}. When undefined, those bits are zero.
//
// Handshake: cmd_vld is a one-clk pulse. It is asserted in the clk after a
// frame of exactly XFER_BITS SCLK rises ends. chnl is valid in that same clk
// and holds its value until the next accepted command. No backpressure.
module a2d_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int XFER_BITS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] ana,
    output logic [2:0]  chnl,
    output logic        cmd_vld,
    output logic        frm_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_d;
    logic                   sclk_d;

    logic ss_s;
    logic sclk_s;
    logic mosi_s;
    logic ss_fall;
    logic ss_rise;
    logic sclk_rise;
    logic sclk_fall;

    // Only the low 14 received bits are kept. Bits [15:14] of the command
    // are never used, and [13:11] land in the same positions either way.
    logic [13:0] rx_shift;
    logic [15:0] tx_shift;
    logic [15:0] resp;
    logic [4:0]  bit_cnt;
    logic        first_fall;
    logic [11:0] sel_val;

    // Bring the asynchronous SPI pins into the clk domain.
    // Each SS_n/SCLK stage resets to the idle-high level. That way reset
    // never manufactures a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_d      <= ss_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // Select the conversion value addressed by the received command.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < 8; k++) begin
            if (rx_shift[13:11] == 3'(k)) begin
                sel_val = ana[12*k +: 12];
            end
        end
    end

    // Frame FSM: handles shifting, command acceptance and framing errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_shift   <= 16'h0000;
            rx_shift   <= '0;
            resp       <= 16'h0000;
            bit_cnt    <= '0;
            first_fall <= 1'b0;
            chnl       <= 3'd0;
            cmd_vld    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            cmd_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_shift   <= resp;
                        bit_cnt    <= '0;
                        first_fall <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state <= DONE;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[12:0], mosi_s};
                            if (bit_cnt != 5'd31) begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        // The first fall only opens the frame. Bit 15 must
                        // still be on MISO at the first rise.
                        if (sclk_fall) begin
                            if (first_fall) begin
                                first_fall <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[14:0], 1'b0};
                            end
                        end
                    end
                end
                DONE: begin
                    if (bit_cnt == 5'(XFER_BITS)) begin
                        chnl    <= rx_shift[13:11];
                        cmd_vld <= 1'b1;
`ifdef A2D_CHAN_TAG_EN
                        resp    <= {1'b0, rx_shift[13:11], sel_val};
`else
                        resp    <= {4'h0, sel_val};
`endif
                    end else begin
                        frm_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MISO      = tx_shift[15];
    assign state_dbg = state;

endmodule

// File: tb/tb_a2d_spi_responder.sv
// Testbench for a2d_spi_responder. It drives SPI frames at SCLK = clk/32.
// A reference model tracks the pending response, latched channel and error
// flag. A monitor compares returned MISO words and cmd_vld/chnl pulses
// against the expected queues.
module tb_a2d_spi_responder;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] ana;
    logic [2:0]  chnl;
    logic        cmd_vld;
    logic        frm_err;
    logic [1:0]  state_dbg;

    int checks;
    int errors;

    // Reference model state
    logic [11:0] ana_arr[8];
    logic [15:0] model_resp;
    logic [2:0]  model_chnl;
    logic        model_err;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [2:0]  exp_chnl_q[$];

    a2d_spi_responder #(.SYNC_STAGES(2), .XFER_BITS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .ana       (ana),
        .chnl      (chnl),
        .cmd_vld   (cmd_vld),
        .frm_err   (frm_err),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_ana(input int ch, input logic [11:0] val);
        ana_arr[ch] = val;
        ana[12*ch +: 12] = val;
    endtask

    task automatic model_reset();
        model_resp = 16'h0000;
        model_chnl = 3'd0;
        model_err  = 1'b0;
    endtask

    // Value a completed command will return in the following frame
    function automatic logic [15:0] model_word(input logic [2:0] sel);
`ifdef A2D_CHAN_TAG_EN
        return {1'b0, sel, ana_arr[sel]};
`else
        return {4'h0, ana_arr[sel]};
`endif
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame of nbits clocks. If rst_at >= 0, reset is asserted
    // in the middle of bit rst_at, and the frame is abandoned.
    task automatic xfer(input logic [15:0] cmd, input int nbits, input int rst_at);
        logic [15:0] got;
        bit full;
        got  = '0;
        full = (nbits == 16) && (rst_at < 0);
        if (full) begin
            exp_q.push_back(model_resp);
            exp_chnl_q.push_back(cmd[13:11]);
        end
        SS_n = 1'b0;
        wait_clks(16);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'($urandom_range(0, 1));
            if (i == rst_at) begin
                wait_clks(4);
                rst_n = 1'b0;
                wait_clks(3);
                SS_n = 1'b1;
                SCLK = 1'b1;
                check("rst_mid_miso", 32'(MISO), 32'h0);
                check("rst_mid_chnl", 32'(chnl), 32'h0);
                check("rst_mid_frm_err", 32'(frm_err), 32'h0);
                check("rst_mid_cmd_vld", 32'(cmd_vld), 32'h0);
                wait_clks(2);
                rst_n = 1'b1;
                model_reset();
                wait_clks(10);
                return;
            end
            wait_clks(16);
            SCLK = 1'b1;
            got  = {got[14:0], MISO};
            wait_clks(16);
        end
        wait_clks(16);
        SS_n = 1'b1;
        wait_clks(12);
        if (full) begin
            model_chnl = cmd[13:11];
            model_resp = model_word(cmd[13:11]);
            got_q.push_back(got);
        end else begin
            model_err = 1'b1;
        end
        check("post_chnl", 32'(chnl), 32'(model_chnl));
        check("post_frm_err", 32'(frm_err), 32'(model_err));
        wait_clks(8);
    endtask

    // SCLK activity with SS_n high must be ignored
    task automatic stray_sclk(input int n);
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b0;
            MOSI = 1'($urandom_range(0, 1));
            wait_clks(16);
            SCLK = 1'b1;
            wait_clks(16);
        end
    endtask

    // Scoreboard monitor: pops expected values when the DUT presents output
    always @(negedge clk) begin
        if (rst_n && cmd_vld) begin
            if (exp_chnl_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd_vld: got chnl %0d with no command expected", chnl);
            end else begin
                check("cmd_vld_chnl", 32'(chnl), 32'(exp_chnl_q.pop_front()));
            end
        end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            check("miso_word", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
    end

    // Stimulus
    initial begin
        logic [15:0] cmd;
        int mode;
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        MOSI  = 1'b0;
        ana   = '0;
        for (int k = 0; k < 8; k++) ana_arr[k] = 12'h000;
        model_reset();
        wait_clks(5);
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_chnl", 32'(chnl), 32'h0);
        check("reset_cmd_vld", 32'(cmd_vld), 32'h0);
        check("reset_frm_err", 32'(frm_err), 32'h0);
        rst_n = 1'b1;
        wait_clks(10);

        // First frame after reset returns zero
        xfer(16'h0000, 16, -1);

        // Channel 1 readback
        set_ana(1, 12'hABC);
        xfer(16'h0800, 16, -1);
        xfer(16'h0800, 16, -1);

        // Round robin over channels 0, 1, 3, 4
        set_ana(0, 12'h111);
        set_ana(1, 12'h222);
        set_ana(3, 12'h333);
        set_ana(4, 12'h444);
        xfer(16'h0000, 16, -1);
        xfer(16'h0800, 16, -1);
        xfer(16'h1800, 16, -1);
        xfer(16'h2000, 16, -1);

        // Snapshot is not affected by later changes on ana
        xfer(16'h1800, 16, -1);
        set_ana(3, 12'hFFF);
        xfer(16'h0000, 16, -1);

        // Aborted frame after 9 SCLKs, then a full read of the prior resp
        xfer(16'h2000, 9, -1);
        xfer(16'h0800, 16, -1);

        // Reset in the middle of bit 7, then behaves as after reset
        xfer(16'h1800, 16, 7);
        check("after_rst_frm_err", 32'(frm_err), 32'h0);
        xfer(16'h0800, 16, -1);
        xfer(16'h0000, 16, -1);

        // SS_n rises before any SCLK
        xfer(16'h0000, 0, -1);
        stray_sclk(3);
        xfer(16'h1000, 16, -1);

        // Randomized frames
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) set_ana($urandom_range(0, 7), 12'($urandom));
            if ($urandom_range(0, 2) == 0) set_ana($urandom_range(0, 7), 12'($urandom));
            cmd  = 16'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                n = $urandom_range(0, 20);
                if (n == 16) n = 15;
                xfer(cmd, n, -1);
            end else begin
                if (mode == 1) stray_sclk($urandom_range(1, 3));
                xfer(cmd, 16, -1);
            end
        end

        wait_clks(50);
        check("exp_chnl_q_drained", 32'(exp_chnl_q.size()), 32'h0);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_spi_responder.md
Name: a2d_spi_responder

Overview:
- SPI slave that models the 8-channel 12-bit A2D converter on the other end of the e-bike A2D SPI link.
- Each 16-bit transaction shifts in a command word whose bits [13:11] select a channel.
- During the next transaction it shifts out that channel's 12-bit conversion result.
- Lives in the bench/FPGA model layer and is driven by the design's SPI master at SCLK = clk/32.

Parameters:
SYNC_STAGES, 2, flop stages synchronizing SCLK, SS_n, MOSI into clk domain (min 2)
XFER_BITS, 16, bits per SPI transaction

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low
SCLK  input  1  SPI clock, idles high
MOSI  input  1  master-out data, MSB first
MISO  output  1  slave-out data, MSB first
ana  input  96  packed analog values; channel k = ana[12*k+11:12*k]
chnl  output  3  channel latched from the most recent complete command
cmd_vld  output  1  one-clk pulse when a complete XFER_BITS command is accepted
frm_err  output  1  sticky; set when SS_n rises with bit count != XFER_BITS

Behaviour:
- Reset: clk and rst_n only; all outputs and internal state asynchronous to rst_n.
  - Reset values: MISO=0, chnl=0, cmd_vld=0, frm_err=0, tx_shift=16'h0000, resp=16'h0000, bit_cnt=0, state=IDLE.
- Synchronizers: SS_n, SCLK, MOSI each pass SYNC_STAGES flops; SCLK/SS_n also pass one extra flop for edge detect.
  - SS_n synchronizer preset to 1 on reset; SCLK synchronizer preset to 1.
  - Edge recognized SYNC_STAGES+1 clks after the pin edge. Requires SCLK half-period >= 8 clk.
- Bus convention: master shifts MOSI on SCLK fall; slave samples MOSI on synchronized SCLK rise.
  - Slave shifts tx_shift left on synchronized SCLK fall, but not on the first fall after SS_n falls (MISO bit 15 must be valid at the first rise).
- MISO = tx_shift[15] at all times.
- States:
  - IDLE: on SS_n fall -> load tx_shift<=resp, bit_cnt<=0, go SHIFT.
  - SHIFT:
    - Each SCLK rise: rx_shift<={rx_shift[14:0],MOSI_s}, bit_cnt++ (saturates at 31).
    - Each non-first SCLK fall: tx_shift<={tx_shift[14:0],1'b0}.
    - On SS_n rise -> go DONE.
  - DONE (1 clk):
    - If bit_cnt==XFER_BITS: chnl<=rx_shift[13:11]; resp<={4'h0, ana[sel]} where sel=rx_shift[13:11], snapshotted this clk; cmd_vld=1.
    - Else: frm_err<=1; chnl and resp unchanged.
    - -> IDLE.
- Response semantics: transaction N returns the value for the channel commanded in transaction N-1, sampled at the end of N-1.
  - First transaction after reset returns 16'h0000.
  - Changes on ana after the snapshot do not affect the in-flight response.
- Ignored bits: rx bits [15:14] and [10:0] are ignored; any value is accepted.
- SS_n rises before first SCLK (bit_cnt=0): frm_err set, no update.
- SS_n falls in DONE: cannot occur for a legal master; in that case DONE completes, then IDLE detects SS_n low-level?
  - No: IDLE needs an edge, so that frame is ignored and MISO shows the stale tx_shift.
- SCLK edges while SS_n high: ignored, no shifting.
- Reset mid-transaction: all state cleared; the next SS_n fall starts cleanly.
- frm_err clears only on reset.

Optional Feature:
- Macro: A2D_CHAN_TAG_EN.
- Defined: resp[15:12] = {1'b0, sel}, so the upper nibble echoes the channel of the returned conversion (master reads only [11:0], so compatible).
- Undefined: resp[15:12] = 4'h0.

Test Plan:
- Reset, then transaction with cmd 16'h0000 -> MISO word 16'h0000; chnl=0; cmd_vld pulses once.
- ana ch1=12'hABC; cmd 16'h0800 (ch1), then a second transaction with cmd 16'h0800 -> second MISO word 16'h0ABC (16'h1ABC with A2D_CHAN_TAG_EN).
- Round-robin cmds for ch0,1,3,4 with values 12'h111,12'h222,12'h333,12'h444 -> each following transaction returns the previous channel's value; chnl tracks 0,1,3,4.
- Change ana ch3 from 12'h333 to 12'hFFF after cmd 16'h1800 completes but before the next SS_n fall -> next read is 16'h0333.
- Abort after 9 SCLKs (SS_n rises early) -> frm_err=1, no cmd_vld, chnl unchanged; next full read returns the prior resp.
- Assert rst_n low at bit 7 of a transaction -> MISO=0, chnl=0, frm_err=0; next full transaction behaves as after reset.
